// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the round-robin PCI bus arbiter.
// Optional priority classes are enabled with the PCI_ARB_PRIO_EN macro.
package pci_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARK,
    ST_GRANT,
    ST_BUSY,
    ST_LAST
  } arb_state_e;

  localparam int unsigned TIMER_W = 8;

  // Index width for an agent vector; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module pci_rr_picker
  import pci_arb_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr < N and i < N, so one conditional subtract gives the modulo.
      cand = SW'(ptr) + SW'(i);
      if (cand >= SW'(N)) begin
        cand = cand - SW'(N);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// Central PCI arbiter: round-robin grants at transaction boundaries, bus
// parking and grant timeout. Define PCI_ARB_PRIO_EN for two priority classes.
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned N_AGENTS    = 8,
  parameter int unsigned GNT_TIMEOUT = 16,
  parameter bit          PARK_EN     = 1'b1,
  parameter int unsigned PARK_AGENT  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_AGENTS-1:0]           REQ_N,
`ifdef PCI_ARB_PRIO_EN
  input  logic [N_AGENTS-1:0]           HI_PRIO,
`endif
  input  logic                          FRAME_N,
  input  logic                          IRDY_N,
  output logic [N_AGENTS-1:0]           GNT_N,
  output logic [idx_w(N_AGENTS)-1:0]    GNT_IDX,
  output logic                          BUS_BUSY,
  output logic                          TIMEOUT_P
);

  localparam int unsigned      IW         = idx_w(N_AGENTS);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GNT_TIMEOUT - 1);
  localparam logic [IW-1:0]    PARK_IDX   = IW'(PARK_AGENT);
  localparam logic [IW-1:0]    LAST_IDX   = IW'(N_AGENTS - 1);

  arb_state_e          state_q, state_d;
  logic [N_AGENTS-1:0] gnt_n_q, gnt_n_d;
  logic [IW-1:0]       gnt_idx_q, gnt_idx_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                bus_busy_q, bus_busy_d;
  logic                timeout_p_q, timeout_p_d;

  logic [N_AGENTS-1:0] req_c;
  logic                req_any_c;
  logic                own_req_c;
  logic                bus_idle_c;
  logic                start_c;
  logic                timeout_hit_c;
  logic                win_found_c;
  logic [IW-1:0]       win_idx_c;
  logic [IW-1:0]       next_ptr_c;

  assign req_c      = ~REQ_N;
  assign req_any_c  = |req_c;
  assign own_req_c  = req_c[gnt_idx_q];
  assign bus_idle_c = FRAME_N & IRDY_N;
  assign next_ptr_c = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IW'(1);

`ifdef PCI_ARB_PRIO_EN
  logic [IW-1:0] rr_ptr_hi_q, rr_ptr_hi_d;
  logic [IW-1:0] rr_ptr_lo_q, rr_ptr_lo_d;
  logic          gnt_hi_q, gnt_hi_d;
  logic          hi_found_c, lo_found_c;
  logic [IW-1:0] hi_idx_c, lo_idx_c;
  logic [N_AGENTS-1:0] req_hi_c, req_lo_c;

  assign req_hi_c = req_c & HI_PRIO;
  assign req_lo_c = req_c & ~HI_PRIO;

  pci_rr_picker #(.N(N_AGENTS), .IW(IW)) u_pick_hi (
    .req   (req_hi_c),
    .ptr   (rr_ptr_hi_q),
    .found (hi_found_c),
    .idx   (hi_idx_c)
  );

  pci_rr_picker #(.N(N_AGENTS), .IW(IW)) u_pick_lo (
    .req   (req_lo_c),
    .ptr   (rr_ptr_lo_q),
    .found (lo_found_c),
    .idx   (lo_idx_c)
  );

  assign win_found_c = hi_found_c | lo_found_c;
  assign win_idx_c   = hi_found_c ? hi_idx_c : lo_idx_c;
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  pci_rr_picker #(.N(N_AGENTS), .IW(IW)) u_pick (
    .req   (req_c),
    .ptr   (rr_ptr_q),
    .found (win_found_c),
    .idx   (win_idx_c)
  );
`endif

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_n_q     <= '1;
      gnt_idx_q   <= '0;
      timer_q     <= '0;
      bus_busy_q  <= 1'b0;
      timeout_p_q <= 1'b0;
`ifdef PCI_ARB_PRIO_EN
      rr_ptr_hi_q <= '0;
      rr_ptr_lo_q <= '0;
      gnt_hi_q    <= 1'b0;
`else
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_n_q     <= gnt_n_d;
      gnt_idx_q   <= gnt_idx_d;
      timer_q     <= timer_d;
      bus_busy_q  <= bus_busy_d;
      timeout_p_q <= timeout_p_d;
`ifdef PCI_ARB_PRIO_EN
      rr_ptr_hi_q <= rr_ptr_hi_d;
      rr_ptr_lo_q <= rr_ptr_lo_d;
      gnt_hi_q    <= gnt_hi_d;
`else
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  // Next state; FRAME_N low takes precedence over withdrawal and timeout.
  always_comb begin
    state_d       = state_q;
    start_c       = 1'b0;
    timeout_hit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          state_d = ST_GRANT;
        end else if (PARK_EN) begin
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        if (!FRAME_N) begin
          state_d = ST_BUSY;
        end else if (!REQ_N[PARK_AGENT]) begin
          state_d = ST_GRANT;
        end else if (req_any_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!FRAME_N) begin
          state_d = ST_BUSY;
          start_c = 1'b1;
        end else if (!own_req_c) begin
          state_d = ST_IDLE;
        end else if (bus_idle_c && (timer_q == TIMER_LAST)) begin
          state_d       = ST_IDLE;
          timeout_hit_c = 1'b1;
        end
      end
      ST_BUSY: begin
        if (FRAME_N) begin
          state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (IRDY_N) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant vector, grantee index, timer and pointer updates.
  always_comb begin
    gnt_n_d     = gnt_n_q;
    gnt_idx_d   = gnt_idx_q;
    timer_d     = timer_q;
    timeout_p_d = timeout_hit_c;
    bus_busy_d  = (state_d == ST_BUSY) || (state_d == ST_LAST);
`ifdef PCI_ARB_PRIO_EN
    rr_ptr_hi_d = rr_ptr_hi_q;
    rr_ptr_lo_d = rr_ptr_lo_q;
    gnt_hi_d    = gnt_hi_q;
`else
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_d)
      ST_IDLE, ST_LAST: begin
        gnt_n_d = '1;
      end
      ST_PARK: begin
        gnt_n_d   = ~(N_AGENTS'(1) << PARK_AGENT);
        gnt_idx_d = PARK_IDX;
      end
      ST_GRANT: begin
        if (state_q == ST_IDLE) begin
          gnt_n_d   = ~(N_AGENTS'(1) << win_idx_c);
          gnt_idx_d = win_idx_c;
          timer_d   = '0;
`ifdef PCI_ARB_PRIO_EN
          gnt_hi_d  = hi_found_c;
`endif
        end else if (state_q == ST_PARK) begin
          timer_d   = '0;
`ifdef PCI_ARB_PRIO_EN
          gnt_hi_d  = HI_PRIO[PARK_AGENT];
`endif
        end else if (bus_idle_c) begin
          timer_d   = timer_q + TIMER_W'(1);
        end
      end
      default: begin
      end
    endcase

    // Only the class that was served moves its pointer past the grantee.
    if (start_c || timeout_hit_c) begin
`ifdef PCI_ARB_PRIO_EN
      if (gnt_hi_q) begin
        rr_ptr_hi_d = next_ptr_c;
      end else begin
        rr_ptr_lo_d = next_ptr_c;
      end
`else
      rr_ptr_d = next_ptr_c;
`endif
    end
  end

  assign GNT_N     = gnt_n_q;
  assign GNT_IDX   = gnt_idx_q;
  assign BUS_BUSY  = bus_busy_q;
  assign TIMEOUT_P = timeout_p_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural model of the arbitration rules.
module tb_pci_rr_arbiter;

  localparam int unsigned N       = 8;
  localparam int unsigned TO      = 4;
  localparam int unsigned PARK_AG = 0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_n;
  logic [N-1:0] hi_prio;
  logic         frame_n;
  logic         irdy_n;
  logic [N-1:0] gnt_n;
  logic [2:0]   gnt_idx;
  logic         bus_busy;
  logic         timeout_p;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pci_rr_arbiter #(
    .N_AGENTS    (N),
    .GNT_TIMEOUT (TO),
    .PARK_EN     (1'b1),
    .PARK_AGENT  (PARK_AG)
  ) dut (
`ifdef PCI_ARB_PRIO_EN
    .HI_PRIO   (hi_prio),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .REQ_N     (req_n),
    .FRAME_N   (frame_n),
    .IRDY_N    (irdy_n),
    .GNT_N     (gnt_n),
    .GNT_IDX   (gnt_idx),
    .BUS_BUSY  (bus_busy),
    .TIMEOUT_P (timeout_p)
  );

  typedef struct {
    logic [N-1:0] req_n;
    logic         frame_n;
    logic         irdy_n;
    logic [N-1:0] gnt_n;
    logic [2:0]   idx;
    logic         busy;
    logic         to;
  } vec_t;

  vec_t vecs[30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [N-1:0] eg, input logic [2:0] ei,
                         input logic eb, input logic et);
    chk({name, "_gnt"},  32'(gnt_n),     32'(eg));
    chk({name, "_idx"},  32'(gnt_idx),   32'(ei));
    chk({name, "_busy"}, 32'(bus_busy),  32'(eb));
    chk({name, "_to"},   32'(timeout_p), 32'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_with(input logic [N-1:0] r);
    rst_n   = 1'b0;
    req_n   = r;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  // Behavioural model: who owns the grant, and what phase the bus is in.
  int m_owner;     // -1 when no grant is driven
  int m_last;      // most recent grantee
  int m_ptr;       // search start
  int m_wait;      // idle cycles spent by the current grantee
  bit m_parked, m_in_txn, m_draining, m_pulse;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int a;
      a = (p + k) % N;
      if (!r[a]) return a;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_wait = 0;
    m_parked = 0; m_in_txn = 0; m_draining = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int w;
    m_pulse = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_draining) begin
      if (irdy_n) m_draining = 0;
    end else if (m_in_txn) begin
      if (frame_n) begin
        m_in_txn = 0; m_draining = 1; m_owner = -1;
      end
    end else if (m_owner < 0) begin
      w = pick(req_n, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_wait = 0;
      end else begin
        m_owner = PARK_AG; m_last = PARK_AG; m_parked = 1;
      end
    end else if (m_parked) begin
      if (!frame_n) begin
        m_parked = 0; m_in_txn = 1;
      end else if (!req_n[PARK_AG]) begin
        m_parked = 0; m_wait = 0;
      end else if (req_n != '1) begin
        m_parked = 0; m_owner = -1;
      end
    end else begin
      if (!frame_n) begin
        m_in_txn = 1; m_ptr = (m_owner + 1) % N;
      end else if (req_n[m_owner]) begin
        m_owner = -1;
      end else if (irdy_n) begin
        if (m_wait == TO - 1) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_pulse = 1;
        end else begin
          m_wait++;
        end
      end
    end
  endtask

  initial begin
    logic [N-1:0] exp_g;
    logic [N-1:0] r;
    int pulses;

    hi_prio = '0;
    rst_n   = 1'b0;
    req_n   = '0;
    frame_n = 1'b1;
    irdy_n  = 1'b1;

    // Round-robin table: agents 0..3 requesting, each runs a 3-cycle FRAME.
    for (int b = 0; b < 5; b++) begin
      int a;
      a = b % 4;
      exp_g = ~(8'h01 << a);
      vecs[b*6+0] = '{8'hF0, 1'b1, 1'b1, exp_g, 3'(a), 1'b0, 1'b0};
      vecs[b*6+1] = '{8'hF0, 1'b0, 1'b1, exp_g, 3'(a), 1'b1, 1'b0};
      vecs[b*6+2] = '{8'hF0, 1'b0, 1'b0, exp_g, 3'(a), 1'b1, 1'b0};
      vecs[b*6+3] = '{8'hF0, 1'b0, 1'b0, exp_g, 3'(a), 1'b1, 1'b0};
      vecs[b*6+4] = '{8'hF0, 1'b1, 1'b0, 8'hFF, 3'(a), 1'b1, 1'b0};
      vecs[b*6+5] = '{8'hF0, 1'b1, 1'b1, 8'hFF, 3'(a), 1'b0, 1'b0};
    end

    // Reset held with all agents requesting, then first grant.
    tick();
    tick();
    chk_out("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("first_grant", 8'hFE, 3'd0, 1'b0, 1'b0);

    reset_with(8'hF0);
    for (int i = 0; i < 30; i++) begin
      req_n   = vecs[i].req_n;
      frame_n = vecs[i].frame_n;
      irdy_n  = vecs[i].irdy_n;
      tick();
      chk_out($sformatf("rr%0d", i), vecs[i].gnt_n, vecs[i].idx, vecs[i].busy, vecs[i].to);
    end

    // Parking, then another agent requests: one dead cycle before its grant.
    reset_with(8'hFF);
    tick();
    chk_out("park", 8'hFE, 3'd0, 1'b0, 1'b0);
    tick();
    chk_out("park_hold", 8'hFE, 3'd0, 1'b0, 1'b0);
    req_n = 8'hDF;
    tick();
    chk("park_dead_gnt", 32'(gnt_n), 32'hFF);
    tick();
    chk_out("park_to_5", 8'hDF, 3'd5, 1'b0, 1'b0);

    // Grant timeout with agent 3 never starting, then re-grant.
    reset_with(8'hF7);
    pulses = 0;
    tick();
    chk_out("to_grant", 8'hF7, 3'd3, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++) begin
      tick();
      pulses += int'(timeout_p);
      chk("to_wait_gnt", 32'(gnt_n), 32'hF7);
    end
    tick();
    pulses += int'(timeout_p);
    chk_out("to_revoke", 8'hFF, 3'd3, 1'b0, 1'b1);
    tick();
    pulses += int'(timeout_p);
    chk_out("to_regrant", 8'hF7, 3'd3, 1'b0, 1'b0);
    chk("to_pulse_count", 32'(pulses), 32'd1);

    // FRAME_N on the timeout cycle wins; then reset mid-transaction.
    reset_with(8'hF7);
    for (int k = 0; k < TO; k++) tick();
    frame_n = 1'b0;
    tick();
    chk_out("to_vs_frame", 8'hF7, 3'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("reset_mid_txn", 8'hFF, 3'd0, 1'b0, 1'b0);
    rst_n   = 1'b1;
    frame_n = 1'b1;

    // Withdrawal together with FRAME_N, then a request during BUSY.
    reset_with(8'hFD);
    tick();
    chk_out("tb_grant1", 8'hFD, 3'd1, 1'b0, 1'b0);
    req_n = 8'hFF; frame_n = 1'b0;
    tick();
    chk_out("withdraw_vs_frame", 8'hFD, 3'd1, 1'b1, 1'b0);
    req_n = 8'hF9; irdy_n = 1'b0;
    tick();
    chk("busy_hold0", 32'(gnt_n), 32'hFD);
    tick();
    chk("busy_hold1", 32'(gnt_n), 32'hFD);
    frame_n = 1'b1;
    tick();
    chk_out("last0", 8'hFF, 3'd1, 1'b1, 1'b0);
    tick();
    chk_out("last_wait_irdy", 8'hFF, 3'd1, 1'b1, 1'b0);
    irdy_n = 1'b1;
    tick();
    chk_out("after_last", 8'hFF, 3'd1, 1'b0, 1'b0);
    tick();
    chk_out("next_owner2", 8'hFB, 3'd2, 1'b0, 1'b0);

    // Randomized traffic against the model.
    reset_with(8'hFF);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        r = '1;
        if ($urandom_range(0, 7) == 0) r = '0;
        else for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) r[b] = 1'b0;
        req_n = r;
      end
      frame_n = ($urandom_range(0, 3) != 0);
      irdy_n  = ($urandom_range(0, 2) != 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      model_step();
      #1;
      exp_g = (m_owner < 0) ? 8'hFF : ~(8'h01 << m_owner);
      chk_out("rand", exp_g, 3'(m_last), m_in_txn | m_draining, m_pulse);
      chk("rand_onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pci_rr_arbiter.md
Name: pci_rr_arbiter

Overview:
Central PCI bus arbiter with round-robin fairness, bus parking and a grant-acceptance timeout.
- Sits between the per-agent REQ_N/GNT_N pairs of the SimpleInitiator instances and the muxed global FRAME_N/IRDY_N.
- Grants ownership to one initiator at a time.
- Re-arbitrates only at transaction boundaries.
- Reclaims a grant the winner does not use.

Parameters:
N_AGENTS, 8, number of requesting initiators (2..16).
GNT_TIMEOUT, 16, idle-bus cycles a granted agent may take before FRAME_N is asserted (2..255).
PARK_EN, 1, 1 = park the bus on PARK_AGENT when no request is pending.
PARK_AGENT, 0, index of the parking agent (< N_AGENTS).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
REQ_N  input  N_AGENTS  per-agent request, active low.
FRAME_N  input  1  global FRAME, active low.
IRDY_N  input  1  global IRDY, active low.
GNT_N  output  N_AGENTS  per-agent grant, active low, registered, at most one bit low.
GNT_IDX  output  $clog2(N_AGENTS)  index of the current or last grantee.
BUS_BUSY  output  1  high in states BUSY and LAST.
TIMEOUT_P  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst_n low at a posedge): GNT_N all ones, GNT_IDX 0, BUS_BUSY 0, TIMEOUT_P 0, state IDLE, rr_ptr 0, timer 0. Reset mid-transaction drops the grant in the same edge.
- Bus idle = FRAME_N & IRDY_N both high.
- Winner: first agent with REQ_N low, searching rr_ptr, rr_ptr+1, ... with wrap modulo N_AGENTS.
- IDLE (GNT_N all ones):
  - any request -> GNT_N[winner]=0, GNT_IDX=winner, timer=0 -> GRANT.
  - else if PARK_EN -> GNT_N[PARK_AGENT]=0 -> PARK.
  - else stay.
- PARK:
  - FRAME_N low -> BUSY.
  - REQ_N[PARK_AGENT] low -> GRANT, grant kept, timer=0.
  - another agent requests -> GNT_N all ones -> IDLE (one dead cycle).
- GRANT:
  - FRAME_N low -> BUSY, rr_ptr = GNT_IDX+1 mod N.
  - REQ_N[GNT_IDX] high (request withdrawn) -> IDLE, grant dropped, rr_ptr unchanged.
  - Timer counts only while the bus is idle. At timer == GNT_TIMEOUT-1 -> IDLE, grant dropped, TIMEOUT_P=1, rr_ptr = GNT_IDX+1.
  - Bus busy (previous owner's final phase): hold, no count.
- BUSY: grant held. FRAME_N high -> LAST, GNT_N all ones.
- LAST: wait until IRDY_N is high -> IDLE.
- Latency: request to grant takes 1 cycle from IDLE and 2 cycles from PARK.
- Grants never overlap. Every grant change passes through at least one all-ones cycle, except PARK->GRANT for the same agent.
- Simultaneous events:
  - FRAME_N low in the same cycle as the timeout: FRAME wins, no pulse.
  - FRAME_N low in the same cycle as the request withdrawal: FRAME wins.
- Fairness: with all N requesting continuously, each agent is granted exactly once in every N consecutive transactions.

Optional Feature:
PCI_ARB_PRIO_EN
- Defined:
  - Extra input HI_PRIO[N_AGENTS].
  - Winner is taken from requesters with HI_PRIO=1 if any exist, else from the low class.
  - Separate rr_ptr_hi and rr_ptr_lo; only the pointer of the served class advances.
- Undefined: port absent, single pointer, behaviour as above.

Decomposition:
- Package pci_arb_pkg:
  - state enum IDLE/PARK/GRANT/BUSY/LAST.
  - IDX_W function/constant.
  - timer width constant (8).
- Sub-module pci_rr_picker: combinational rotate + priority-encode.
  - Inputs: req vector, pointer.
  - Outputs: found, idx.
  - Instantiated once, or twice under PCI_ARB_PRIO_EN.

Test Plan:
- Reset: hold rst_n=0 with REQ_N=8'h00 -> GNT_N=8'hFF, GNT_IDX=0, BUS_BUSY=0. First posedge after release -> GNT_N=8'hFE.
- Round robin: REQ_N=8'hF0 held, each grantee drives a 3-cycle FRAME_N -> grant order 0,1,2,3,0. A dead cycle (GNT_N=8'hFF) precedes each new grant.
- Parking: PARK_EN=1, REQ_N=8'hFF -> GNT_N=8'hFE. Then REQ_N[5]=0 -> GNT_N=8'hFF for 1 cycle, then 8'hDF.
- Timeout: GNT_TIMEOUT=4, REQ_N=8'hF7, agent 3 never asserts FRAME_N -> grant revoked 4 idle cycles after grant, TIMEOUT_P pulses once. Agent 3 is re-granted next (it is the only requester).
- Transaction boundary: REQ_N[2]=0 while agent 1 is in BUSY -> GNT_N[1] stays low until FRAME_N rises. GNT_N[2] goes low only after IRDY_N is high.
- PCI_ARB_PRIO_EN: REQ_N=8'h00, HI_PRIO=8'h80 -> agent 7 granted first. After its transaction, if REQ_N[7] is high -> low-class order 0,1,2....
